// File: rtl/dispense_controller.sv
// Dispense sequencer: latches the requested volume on OK, drives the valve and counts flow pulses to the target.
// Latency: 1 clock from a sampled input edge to the registered output change; clear_entry is a 1-cycle pulse per exit.
// Backpressure: none; the optional no-flow timeout / FAULT path is compiled in when DISPENSE_TIMEOUT_EN is defined.
module dispense_controller #(
    parameter int AMOUNT_WIDTH     = 14,
    parameter int MAXIMUM_AMOUNT   = 9999,
    parameter int PULSE_ML         = 5,
    parameter int TIMEOUT_CYCLES   = 50_000_000,
    parameter int DONE_HOLD_CYCLES = 100_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [AMOUNT_WIDTH-1:0] requested_amount,
    input  logic                    button_ok,
    input  logic                    button_cancel,
    input  logic                    flow_pulse,
    output logic                    valve_open,
    output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
    output logic                    busy,
    output logic                    done,
    output logic                    fault,
    output logic                    clear_entry
);

    localparam int TIMER_MAX = (TIMEOUT_CYCLES > DONE_HOLD_CYCLES) ? TIMEOUT_CYCLES : DONE_HOLD_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int SUM_W     = AMOUNT_WIDTH + 1;
    localparam logic [SUM_W-1:0]        SAT_MAX   = {1'b0, {AMOUNT_WIDTH{1'b1}}};
    localparam logic [AMOUNT_WIDTH-1:0] AMT_MAX   = AMOUNT_WIDTH'(MAXIMUM_AMOUNT);
    localparam logic [TIMER_W-1:0]      HOLD_LAST = TIMER_W'(DONE_HOLD_CYCLES - 1);
`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [TIMER_W-1:0]      TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPENSING,
        ST_DONE,
        ST_FAULT
    } state_t;

    state_t                  state_q, state_d;
    logic [AMOUNT_WIDTH-1:0] target_q, target_d;
    logic [AMOUNT_WIDTH-1:0] disp_q, disp_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic                    ok_prev_q, cancel_prev_q, flow_prev_q;
    logic                    valve_open_q, valve_open_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fault_q, fault_d;
    logic                    clear_entry_q, clear_entry_d;

    logic                    ok_edge, cancel_edge, flow_edge, amount_ok;
    logic [SUM_W-1:0]        sum;
    logic [AMOUNT_WIDTH-1:0] disp_inc;

    always_comb begin
        ok_edge     = button_ok & ~ok_prev_q;
        cancel_edge = button_cancel & ~cancel_prev_q;
        flow_edge   = flow_pulse & ~flow_prev_q;
        amount_ok   = (requested_amount != '0) && (requested_amount <= AMT_MAX);
        sum         = {1'b0, disp_q} + SUM_W'(PULSE_ML);
        disp_inc    = (sum > SAT_MAX) ? {AMOUNT_WIDTH{1'b1}} : sum[AMOUNT_WIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        disp_d        = disp_q;
        timer_d       = timer_q;
        clear_entry_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cancel_edge) begin
                    clear_entry_d = 1'b1;
                end else if (ok_edge && amount_ok) begin
                    target_d = requested_amount;
                    disp_d   = '0;
                    timer_d  = '0;
                    state_d  = ST_DISPENSING;
                end
            end
            ST_DISPENSING: begin
                // A flow edge is counted even when cancel wins the same cycle.
                if (flow_edge) begin
                    disp_d  = disp_inc;
                    timer_d = '0;
                end
`ifdef DISPENSE_TIMEOUT_EN
                else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
                if (cancel_edge) begin
                    state_d       = ST_IDLE;
                    clear_entry_d = 1'b1;
                end else if (flow_edge && (disp_inc >= target_q)) begin
                    state_d = ST_DONE;
                    timer_d = '0;
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (!flow_edge && (timer_q == TIMEOUT_LAST)) begin
                    state_d = ST_FAULT;
                end
`endif
            end
            ST_DONE: begin
                timer_d = timer_q + TIMER_W'(1);
                if (cancel_edge || ok_edge || (timer_q == HOLD_LAST)) begin
                    state_d       = ST_IDLE;
                    clear_entry_d = 1'b1;
                    timer_d       = '0;
                end
            end
            ST_FAULT: begin
                if (cancel_edge) begin
                    state_d       = ST_IDLE;
                    clear_entry_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        valve_open_d = (state_d == ST_DISPENSING);
        busy_d       = (state_d == ST_DISPENSING);
        done_d       = (state_d == ST_DONE);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            disp_q        <= '0;
            timer_q       <= '0;
            ok_prev_q     <= 1'b1;
            cancel_prev_q <= 1'b1;
            flow_prev_q   <= 1'b1;
            valve_open_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            clear_entry_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            disp_q        <= disp_d;
            timer_q       <= timer_d;
            ok_prev_q     <= button_ok;
            cancel_prev_q <= button_cancel;
            flow_prev_q   <= flow_pulse;
            valve_open_q  <= valve_open_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            clear_entry_q <= clear_entry_d;
        end
    end

    assign valve_open       = valve_open_q;
    assign dispensed_amount = disp_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign clear_entry      = clear_entry_q;
`ifdef DISPENSE_TIMEOUT_EN
    assign fault            = fault_q;
`else
    assign fault            = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: directed scenarios plus randomized orders against a volume-level reference model.
module tb_dispense_controller;

    localparam int W     = 14;
    localparam int PML   = 5;
    localparam int TOUT  = 8;
    localparam int DHOLD = 20;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] requested_amount = '0;
    logic         button_ok = 1'b0;
    logic         button_cancel = 1'b0;
    logic         flow_pulse = 1'b0;
    logic         valve_open, busy, done, fault, clear_entry;
    logic [W-1:0] dispensed_amount;

    int compared   = 0;
    int mismatched = 0;

    dispense_controller #(
        .AMOUNT_WIDTH    (W),
        .MAXIMUM_AMOUNT  (9999),
        .PULSE_ML        (PML),
        .TIMEOUT_CYCLES  (TOUT),
        .DONE_HOLD_CYCLES(DHOLD)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .requested_amount(requested_amount),
        .button_ok       (button_ok),
        .button_cancel   (button_cancel),
        .flow_pulse      (flow_pulse),
        .valve_open      (valve_open),
        .dispensed_amount(dispensed_amount),
        .busy            (busy),
        .done            (done),
        .fault           (fault),
        .clear_entry     (clear_entry)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic b, input logic d,
                              input logic f, input logic c, input int amt);
        check({tag, ".valve"}, valve_open, v);
        check({tag, ".busy"}, busy, b);
        check({tag, ".done"}, done, d);
        check({tag, ".fault"}, fault, f);
        check({tag, ".clear"}, clear_entry, c);
        check({tag, ".amount"}, dispensed_amount, amt);
    endtask

    task automatic press_ok();
        button_ok = 1'b1;
        step();
    endtask

    task automatic release_ok();
        button_ok = 1'b0;
        step();
    endtask

    // Flow edge sampled on the first step; outputs checked by caller after it.
    task automatic flow_high();
        flow_pulse = 1'b1;
        step();
    endtask

    task automatic flow_low();
        flow_pulse = 1'b0;
        step();
    endtask

    initial begin
        int target, needed, pulses;

        // Reset
        step();
        step();
        reset = 1'b0;
        step();
        check_outs("reset", 0, 0, 0, 0, 0, 0);

        // Basic 20 mL order
        requested_amount = 14'd20;
        press_ok();
        check_outs("t1.start", 1, 1, 0, 0, 0, 0);
        release_ok();
        for (int i = 1; i <= 4; i++) begin
            flow_high();
            check("t1.amount", dispensed_amount, i * PML);
            check("t1.valve", valve_open, (i < 4) ? 1'b1 : 1'b0);
            check("t1.done", done, (i == 4) ? 1'b1 : 1'b0);
            flow_low();
        end
        press_ok();
        check_outs("t1.okexit", 0, 0, 0, 0, 1, 20);
        release_ok();
        check("t1.clearpulse", clear_entry, 0);

        // Invalid amounts are ignored
        requested_amount = 14'd0;
        press_ok();
        check_outs("t2.zero", 0, 0, 0, 0, 0, 20);
        release_ok();
        requested_amount = 14'd10000;
        press_ok();
        check_outs("t2.over", 0, 0, 0, 0, 0, 20);
        release_ok();

        // Cancel after 3 pulses on target 100
        requested_amount = 14'd100;
        press_ok();
        release_ok();
        for (int i = 0; i < 3; i++) begin
            flow_high();
            flow_low();
        end
        button_cancel = 1'b1;
        step();
        check_outs("t3.cancel", 0, 0, 0, 0, 1, 15);
        button_cancel = 1'b0;
        step();
        check("t3.clearpulse", clear_entry, 0);

        // Cancel coincides with the completing flow edge
        requested_amount = 14'd10;
        press_ok();
        release_ok();
        flow_high();
        flow_low();
        button_cancel = 1'b1;
        flow_pulse    = 1'b1;
        step();
        check_outs("t4.tie", 0, 0, 0, 0, 1, 10);
        button_cancel = 1'b0;
        flow_pulse    = 1'b0;
        step();

        // Automatic return to idle after the done hold time
        requested_amount = 14'd5;
        press_ok();
        release_ok();
        flow_high();
        check("t5.done", done, 1);
        flow_low();
        for (int i = 0; i < DHOLD - 2; i++) step();
        check_outs("t5.hold", 0, 0, 1, 0, 0, 5);
        step();
        check_outs("t5.expire", 0, 0, 0, 0, 1, 5);
        step();

        // No-flow timeout
        requested_amount = 14'd50;
        press_ok();
        check("t6.start", valve_open, 1);
        button_ok = 1'b0;
        for (int i = 0; i < TOUT - 1; i++) step();
        check_outs("t6.pre", 1, 1, 0, 0, 0, 0);
        step();
`ifdef DISPENSE_TIMEOUT_EN
        check_outs("t6.fault", 0, 0, 0, 1, 0, 0);
        press_ok();
        check_outs("t6.okign", 0, 0, 0, 1, 0, 0);
        release_ok();
`else
        check_outs("t6.nofault", 1, 1, 0, 0, 0, 0);
`endif
        button_cancel = 1'b1;
        step();
        check_outs("t6.cancel", 0, 0, 0, 0, 1, 0);
        button_cancel = 1'b0;
        step();

        // Reset mid-dispense with ok held through reset release
        requested_amount = 14'd50;
        press_ok();
        release_ok();
        flow_high();
        flow_low();
        button_ok = 1'b1;
        reset     = 1'b1;
        step();
        check_outs("t7.reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        step();
        check("t7.held", valve_open, 0);
        release_ok();
        press_ok();
        check("t7.repress", valve_open, 1);
        button_ok     = 1'b0;
        button_cancel = 1'b1;
        step();
        button_cancel = 1'b0;
        step();

        // Randomized orders: completion needs ceil(target/PML) pulses
        for (int n = 0; n < 8; n++) begin
            target = $urandom_range(1, 200);
            needed = (target + PML - 1) / PML;
            pulses = $urandom_range(0, needed);
            requested_amount = W'(target);
            press_ok();
            check("rnd.start", dispensed_amount, 0);
            release_ok();
            for (int i = 1; i <= pulses; i++) begin
                repeat ($urandom_range(0, 3)) step();
                flow_high();
                check("rnd.amount", dispensed_amount, i * PML);
                check("rnd.valve", valve_open, (i < needed) ? 1'b1 : 1'b0);
                flow_low();
            end
            check("rnd.done", done, (pulses == needed) ? 1'b1 : 1'b0);
            button_cancel = 1'b1;
            step();
            check_outs("rnd.exit", 0, 0, 0, 0, 1, pulses * PML);
            button_cancel = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
